// File: rtl/mm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mm_pkg                                                 |
// | Description : Shared types and constants for the matrix-multiply     |
// |               sequencing controller (state encoding, default sizes,  |
// |               pass and run lengths).                                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mm_pkg;

  localparam int N_DEF      = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF  = 11;

  // One pass = CLEAR + N READ + DRAIN + WR1 + WR2
  localparam int PASS_CYC  = N_DEF + 4;
  // N rows, N/2 column pairs per row
  localparam int TOTAL_CYC = (N_DEF / 2) * N_DEF * PASS_CYC;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WR1   = 3'd4,
    ST_WR2   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mm_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mm_addr_gen                                            |
// | Description : row/col/k counters and address generation for the     |
// |               matrix-multiply sequencer.                             |
// | Ports       : clk, reset (async, active-low)                         |
// |               clr       - zero row, col and k                        |
// |               step_k    - advance k (wraps to 0 after N-1)           |
// |               next_pair - advance to the next column pair / row      |
// |               read      - READ state: drive live read addresses      |
// |               wr, wr_sel- write state and column select for c_addr   |
// |               last_k, last_pair - end-of-dot-product / end-of-run    |
// |               addr_a, addr_b1, addr_b2, c_addr - address outputs     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mm_addr_gen #(
  parameter int N      = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step_k,
  input  logic              next_pair,
  input  logic              read,
  input  logic              wr,
  input  logic              wr_sel,
  output logic              last_k,
  output logic              last_pair,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b1,
  output logic [ADDR_W-1:0] addr_b2,
  output logic [ADDR_W-1:0] c_addr
);

  localparam logic [ADDR_W-1:0] c_n        = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] c_last_col = ADDR_W'(N - 2);

  logic [ADDR_W-1:0] r_row, r_col, r_k;
  logic [ADDR_W-1:0] r_hold_a, r_hold_b1, r_hold_b2;
  logic [ADDR_W-1:0] w_a, w_b1, w_b2;

  assign w_a  = r_row * c_n + r_k;
  assign w_b1 = r_k * c_n + r_col;
  assign w_b2 = w_b1 + ADDR_W'(1);

  assign last_k    = (r_k == c_last_idx);
  assign last_pair = (r_row == c_last_idx) && (r_col == c_last_col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else if (clr) begin
      r_row <= '0;
      r_col <= '0;
      r_k   <= '0;
    end else begin
      if (step_k)
        r_k <= last_k ? '0 : r_k + ADDR_W'(1);
      // On the final pair the counters stay put; the next start clears them.
      if (next_pair && !last_pair) begin
        if (r_col == c_last_col) begin
          r_col <= '0;
          r_row <= r_row + ADDR_W'(1);
        end else begin
          r_col <= r_col + ADDR_W'(2);
        end
      end
    end
  end

  // Read addresses keep the last issued value outside READ so the RAMs
  // see no spurious address activity between passes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_a  <= '0;
      r_hold_b1 <= '0;
      r_hold_b2 <= '0;
    end else if (read) begin
      r_hold_a  <= w_a;
      r_hold_b1 <= w_b1;
      r_hold_b2 <= w_b2;
    end
  end

  assign addr_a  = read ? w_a  : r_hold_a;
  assign addr_b1 = read ? w_b1 : r_hold_b1;
  assign addr_b2 = read ? w_b2 : r_hold_b2;
  assign c_addr  = wr ? (r_row * c_n + r_col + ADDR_W'(wr_sel)) : '0;

endmodule
`default_nettype wire

// File: rtl/mat_mult_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mat_mult_sched                                         |
// | Description : Sequencing controller for C = A x B (NxN, int8). Each  |
// |               pass computes two C columns (MAC0: col, MAC1: col+1)   |
// |               then writes both results to the output RAM.            |
// | Ports       : clk, reset (async, active-low), start, abort           |
// |               addr_a/addr_b1/addr_b2 - RAM read addresses            |
// |               mac_clr/mac_en         - MAC control                   |
// |               c_we/c_sel/c_addr      - output RAM write              |
// |               busy, done, cycle_count - status                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mat_mult_sched
  import mm_pkg::*;
#(
  parameter int N      = N_DEF,      // even, N*N <= 2**ADDR_W
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b1,
  output logic [ADDR_W-1:0] addr_b2,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              c_we,
  output logic              c_sel,
  output logic [ADDR_W-1:0] c_addr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           r_state, w_next;
  logic             r_rd_issued;
  logic [CNT_W-1:0] r_cycles;
  logic             w_accept, w_clr, w_step_k, w_next_pair;
  logic             w_read, w_wr, w_last_k, w_last_pair;

  // start is only honoured when idle or done, and abort always wins
  assign w_accept    = start && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_clr       = w_accept || abort;
  assign w_step_k    = (r_state == ST_READ) && !abort;
  assign w_next_pair = (r_state == ST_WR2) && !abort;

  mm_addr_gen #(
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clr       (w_clr),
    .step_k    (w_step_k),
    .next_pair (w_next_pair),
    .read      (w_read),
    .wr        (w_wr),
    .wr_sel    (c_sel),
    .last_k    (w_last_k),
    .last_pair (w_last_pair),
    .addr_a    (addr_a),
    .addr_b1   (addr_b1),
    .addr_b2   (addr_b2),
    .c_addr    (c_addr)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start) w_next = ST_CLEAR;
        ST_CLEAR:         w_next = ST_READ;
        ST_READ:          if (w_last_k) w_next = ST_DRAIN;
        ST_DRAIN:         w_next = ST_WR1;
        ST_WR1:           w_next = ST_WR2;
        ST_WR2:           w_next = w_last_pair ? ST_DONE : ST_CLEAR;
        default:          w_next = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    w_read  = (r_state == ST_READ);
    w_wr    = (r_state == ST_WR1) || (r_state == ST_WR2);
    mac_clr = (r_state == ST_CLEAR);
    // RAM data arrives one cycle after the read, so accumulate in the
    // cycle following each issued read (READ k>=1 and DRAIN).
    mac_en  = r_rd_issued && ((r_state == ST_READ) || (r_state == ST_DRAIN));
    c_we    = w_wr;
    c_sel   = (r_state == ST_WR2);
    busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    done    = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_issued <= 1'b0;
    else        r_rd_issued <= (r_state == ST_READ);
  end

  // Counts busy cycles; frozen on abort and in DONE, saturates at max.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cycles <= '0;
    else if (w_accept)
      r_cycles <= '0;
    else if (busy && !abort && (r_cycles != c_cnt_max))
      r_cycles <= r_cycles + CNT_W'(1);
  end

  assign cycle_count = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mat_mult_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mat_mult_sched                                      |
// | Description : Self-checking bench for mat_mult_sched with a RAM/MAC  |
// |               environment model and a reference matrix product.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mat_mult_sched;

  localparam int N     = 8;
  localparam int AW    = 8;
  localparam int CW    = 11;
  localparam int PASS  = N + 4;
  localparam int TOTAL = (N / 2) * N * PASS;
  localparam int NN    = N * N;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] addr_a, addr_b1, addr_b2, c_addr;
  logic          mac_clr, mac_en, c_we, c_sel, busy, done;
  logic [CW-1:0] cycle_count;

  mat_mult_sched #(.N(N), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .addr_a      (addr_a),
    .addr_b1     (addr_b1),
    .addr_b2     (addr_b2),
    .mac_clr     (mac_clr),
    .mac_en      (mac_en),
    .c_we        (c_we),
    .c_sel       (c_sel),
    .c_addr      (c_addr),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Datapath environment: 1-cycle RAMs, two MACs, output RAM
  logic signed [7:0] mem_a [0:255];
  logic signed [7:0] mem_b [0:255];
  logic signed [7:0] rd_a, rd_b1, rd_b2;
  int                acc0, acc1;
  int                mem_c  [0:255];
  int                wr_cnt [0:255];
  int                ref_c  [0:NN-1];
  int                first_c[0:NN-1];
  logic              env_clr = 1'b0;

  always @(posedge clk) begin
    rd_a  <= mem_a[addr_a];
    rd_b1 <= mem_b[addr_b1];
    rd_b2 <= mem_b[addr_b2];
    if (mac_clr) begin
      acc0 <= 0;
      acc1 <= 0;
    end else if (mac_en) begin
      acc0 <= acc0 + int'(rd_a) * int'(rd_b1);
      acc1 <= acc1 + int'(rd_a) * int'(rd_b2);
    end
    if (env_clr) begin
      for (int i = 0; i < 256; i++) begin
        mem_c[i]  <= 0;
        wr_cnt[i] <= 0;
      end
    end else if (c_we) begin
      mem_c[c_addr]  <= c_sel ? acc1 : acc0;
      wr_cnt[c_addr] <= wr_cnt[c_addr] + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compute_ref();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ref_c[i*N+j] = 0;
        for (int k = 0; k < N; k++)
          ref_c[i*N+j] += int'(mem_a[i*N+k]) * int'(mem_b[k*N+j]);
      end
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = (i < NN) ? 8'($urandom) : 8'sd0;
      mem_b[i] = (i < NN) ? 8'($urandom) : 8'sd0;
    end
    compute_ref();
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({addr_a, addr_b1, addr_b2, c_addr, cycle_count,
                mac_clr, mac_en, c_we, c_sel, busy, done});
  endfunction

  function automatic logic [63:0] ctl_vec();
    return 64'({mac_clr, mac_en, c_we, c_sel, busy, done});
  endfunction

  // Expected outputs t cycles after the accepting edge, derived from the
  // pass structure: CLEAR, N reads, DRAIN, WR1, WR2 per column pair.
  task automatic expect_cycle(input string tag, input int t);
    int pass, ph, row, col, k;
    logic [5:0] ctl;   // {mac_clr, mac_en, c_we, c_sel, busy, done}
    pass = t / PASS;
    ph   = t % PASS;
    row  = pass / (N / 2);
    col  = 2 * (pass % (N / 2));
    if (ph == 0)          ctl = 6'b100010;
    else if (ph <= N)     ctl = {1'b0, (ph > 1), 4'b0010};
    else if (ph == N + 1) ctl = 6'b010010;
    else if (ph == N + 2) ctl = 6'b001010;
    else                  ctl = 6'b001110;
    check_eq($sformatf("%s t=%0d ctl", tag, t), ctl_vec(), 64'(ctl));
    check_eq($sformatf("%s t=%0d cnt", tag, t), 64'(cycle_count), 64'(t));
    if (ph >= 1) begin
      k = (ph <= N) ? ph - 1 : N - 1;
      check_eq($sformatf("%s t=%0d addr", tag, t),
               64'({addr_a, addr_b1, addr_b2}),
               64'({8'(row*N + k), 8'(k*N + col), 8'(k*N + col + 1)}));
    end
    if (ph >= N + 2)
      check_eq($sformatf("%s t=%0d c_addr", tag, t), 64'(c_addr),
               64'(row*N + col + (ph - N - 2)));
  endtask

  // stop_kind: 0 = full run, 1 = abort at cycle stop_t, 2 = async reset
  task automatic run_mult(input string tag, input bit rand_start,
                          input int stop_t, input int stop_kind);
    int held;
    env_clr = 1'b1;
    @(negedge clk);
    env_clr = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    for (int t = 0; t < TOTAL; t++) begin
      expect_cycle(tag, t);
      start = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stop_kind != 0 && t == stop_t) begin
        start = 1'b0;
        if (stop_kind == 1) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          check_eq({tag, " abort ctl"}, ctl_vec(), 64'd0);
          check_eq({tag, " abort cnt"}, 64'(cycle_count), 64'(t));
          held = int'(cycle_count);
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("%s idle %0d we/cnt", tag, i),
                     64'({c_we, cycle_count}), 64'({1'b0, CW'(held)}));
          end
        end else begin
          #2 reset = 1'b0;
          #1 check_eq({tag, " async reset outs"}, all_outputs(), 64'd0);
          @(negedge clk);
          check_eq({tag, " reset held outs"}, all_outputs(), 64'd0);
          reset = 1'b1;
        end
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_eq({tag, " done ctl"}, ctl_vec(), 64'b000001);
    check_eq({tag, " done cnt"}, 64'(cycle_count), 64'(TOTAL));
    for (int i = 0; i < NN; i++) begin
      check_eq($sformatf("%s C[%0d]", tag, i), 64'(mem_c[i]), 64'(ref_c[i]));
      check_eq($sformatf("%s writes[%0d]", tag, i), 64'(wr_cnt[i]), 64'd1);
    end
    @(negedge clk);
    check_eq({tag, " done frozen"}, 64'({done, busy, cycle_count}),
             64'({1'b1, 1'b0, CW'(TOTAL)}));
  endtask

  initial begin
    // identity A, ramp B
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = (i < NN && (i / N) == (i % N)) ? 8'sd1 : 8'sd0;
      mem_b[i] = (i < NN) ? 8'(i * 3 - 90) : 8'sd0;
    end
    compute_ref();

    #1 reset = 1'b0;
    #1 check_eq("reset outs", all_outputs(), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle outs", all_outputs(), 64'd0);

    run_mult("ident", 1'b0, -1, 0);
    for (int i = 0; i < NN; i++) first_c[i] = mem_c[i];

    // restart straight from DONE with the same data
    run_mult("restart", 1'b0, -1, 0);
    for (int i = 0; i < NN; i++)
      check_eq($sformatf("restart same C[%0d]", i), 64'(mem_c[i]), 64'(first_c[i]));

    load_random();
    run_mult("rand_start_spam", 1'b1, -1, 0);

    load_random();
    run_mult("abort", 1'b0, 3*PASS + 4, 1);
    run_mult("after_abort", 1'b0, -1, 0);

    load_random();
    run_mult("areset", 1'b0, 2*PASS + N + 2, 2);
    run_mult("after_reset", 1'b1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
